// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: branch resolve, data memory, MEM/WB register; wait states under MEM_WAIT_STATE_EN
module mem_wb_stage #(
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        startin,
  input  logic [1:0]  MEM_wb,
  input  logic        MEM_branch,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [31:0] MEM_branch_target,
  input  logic        MEM_zero,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_reg_data2,
  input  logic [4:0]  MEM_reg_dst_mux_out,
  output logic        pc_src,
  output logic [31:0] pc_branch_target,
  output logic        mem_stall,
  output logic [1:0]  WB_wb,
  output logic [31:0] WB_mem_data,
  output logic [31:0] WB_alu_result,
  output logic [4:0]  WB_reg_dst_mux_out
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic          complete;

  // Only the word index bits select the memory; byte offset and high bits are dropped.
  assign idx   = MEM_alu_result[AW+1:2];
  assign rdata = mem[idx];

  logic unused_addr;
  assign unused_addr = ^{MEM_alu_result[31:AW+2], MEM_alu_result[1:0]};

  // Branch decision goes straight to the PC mux, suppressed during reset.
  assign pc_src           = !startin & MEM_branch & MEM_zero;
  assign pc_branch_target = startin ? 32'h0 : MEM_branch_target;

`ifdef MEM_WAIT_STATE_EN
  localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT_C = CW'(MEM_LATENCY);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          request;
  logic          stall;

  assign request   = MEM_mem_read | MEM_mem_write;
  assign mem_stall = stall;

  // Decide whether this edge completes the instruction or inserts a bubble.
  always_comb begin
    complete = 1'b0;
    stall    = 1'b0;
    if (!startin) begin
      if (state == IDLE) begin
        if (!request || MEM_LATENCY == 0) complete = 1'b1;
        else                              stall    = 1'b1;
      end else begin
        if (cnt == LAT_C) complete = 1'b1;
        else              stall    = 1'b1;
      end
    end
  end

  // Wait-state sequencer; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (startin) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request && MEM_LATENCY != 0) begin
            state <= WAIT;
            cnt   <= CW'(1);
          end
        end
        WAIT: begin
          if (cnt == LAT_C) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
`else
  logic unused_read;
  assign unused_read = MEM_mem_read;
  assign complete    = !startin;
  assign mem_stall   = 1'b0;
`endif

  // Store commits only on the completing edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (complete && MEM_mem_write) mem[idx] <= MEM_reg_data2;
  end

  // MEM/WB register: full load on completion, bubble (WB_wb cleared) while waiting.
  always_ff @(posedge clk) begin
    if (startin) begin
      WB_wb              <= 2'b00;
      WB_mem_data        <= 32'h0;
      WB_alu_result      <= 32'h0;
      WB_reg_dst_mux_out <= 5'h0;
    end else if (complete) begin
      WB_wb              <= MEM_wb;
      WB_mem_data        <= rdata;
      WB_alu_result      <= MEM_alu_result;
      WB_reg_dst_mux_out <= MEM_reg_dst_mux_out;
    end else begin
      WB_wb <= 2'b00;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

`ifdef MEM_WAIT_STATE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        startin;
  logic [1:0]  MEM_wb;
  logic        MEM_branch;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic [31:0] MEM_branch_target;
  logic        MEM_zero;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_reg_data2;
  logic [4:0]  MEM_reg_dst_mux_out;
  logic        pc_src;
  logic [31:0] pc_branch_target;
  logic        mem_stall;
  logic [1:0]  WB_wb;
  logic [31:0] WB_mem_data;
  logic [31:0] WB_alu_result;
  logic [4:0]  WB_reg_dst_mux_out;

  int vectors;
  int miscompares;

  logic [70:0] exp_q [$];
  logic [70:0] mask_q [$];
  logic [31:0] model [int];

  mem_wb_stage #(.MEM_WORDS(256), .MEM_LATENCY(2)) dut (
    .clk(clk), .startin(startin), .MEM_wb(MEM_wb), .MEM_branch(MEM_branch),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write),
    .MEM_branch_target(MEM_branch_target), .MEM_zero(MEM_zero),
    .MEM_alu_result(MEM_alu_result), .MEM_reg_data2(MEM_reg_data2),
    .MEM_reg_dst_mux_out(MEM_reg_dst_mux_out), .pc_src(pc_src),
    .pc_branch_target(pc_branch_target), .mem_stall(mem_stall), .WB_wb(WB_wb),
    .WB_mem_data(WB_mem_data), .WB_alu_result(WB_alu_result),
    .WB_reg_dst_mux_out(WB_reg_dst_mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drive one instruction, push its expected WB fields, and ride out any stall.
  task automatic send(input logic [1:0] wb, input logic br, input logic zero,
                      input logic [31:0] tgt, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rdst, output int stalls,
                      output bit bubble_ok, output logic pcs, output logic [31:0] pct);
    logic [70:0] e;
    logic [70:0] m;
    int k;
    @(negedge clk);
    MEM_wb = wb; MEM_branch = br; MEM_zero = zero; MEM_branch_target = tgt;
    MEM_mem_read = rd; MEM_mem_write = wr; MEM_alu_result = addr;
    MEM_reg_data2 = wdata; MEM_reg_dst_mux_out = rdst;
    k = int'(addr[9:2]);
    e = {wb, 32'h0, addr, rdst};
    m = {2'b11, 32'h0, 32'hFFFF_FFFF, 5'h1F};
    if (model.exists(k)) begin
      e[68:37] = model[k];
      m[68:37] = 32'hFFFF_FFFF;
    end
    if (wr) model[k] = wdata;
    exp_q.push_back(e);
    mask_q.push_back(m);
    #1;
    pcs = pc_src;
    pct = pc_branch_target;
    stalls = 0;
    bubble_ok = 1'b1;
    while (mem_stall === 1'b1 && stalls < 16) begin
      stalls++;
      @(posedge clk); #1;
      if (WB_wb !== 2'b00) bubble_ok = 1'b0;
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    MEM_mem_read = 1'b0; MEM_mem_write = 1'b0; MEM_branch = 1'b0; MEM_zero = 1'b0;
  endtask

  task automatic test_reset();
    startin = 1'b1;
    MEM_wb = 2'b11; MEM_branch = 1'b1; MEM_zero = 1'b1; MEM_branch_target = 32'h80;
    MEM_mem_read = 1'b1; MEM_mem_write = 1'b0; MEM_alu_result = 32'h200;
    MEM_reg_data2 = 32'h0; MEM_reg_dst_mux_out = 5'd9;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b want=0", mem_stall); end
    vectors++;
    if (pc_src !== 1'b0) begin miscompares++; $display("FAIL reset_pc_src got=%b want=0", pc_src); end
    vectors++;
    if (pc_branch_target !== 32'h0) begin miscompares++; $display("FAIL reset_pc_target got=%h want=0", pc_branch_target); end
    vectors++;
    if ({WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst_mux_out} !== 71'h0) begin
      miscompares++;
      $display("FAIL reset_wb got=%h/%h/%h/%h want=0", WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst_mux_out);
    end
    startin = 1'b0;
    MEM_mem_read = 1'b0; MEM_branch = 1'b0; MEM_zero = 1'b0;
  endtask

  task automatic test_store_load();
    int s; bit b; logic p; logic [31:0] t;
    logic [70:0] obs, e, m;
    logic [31:0] wd [3];
    logic        rdv [3];
    logic        wrv [3];
    wd[0] = 32'hDEADBEEF; rdv[0] = 1'b0; wrv[0] = 1'b1;
    wd[1] = 32'h0;        rdv[1] = 1'b1; wrv[1] = 1'b0;
    wd[2] = 32'h0BADF00D; rdv[2] = 1'b1; wrv[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) send(2'b11, 1'b0, 1'b0, 32'h0, rdv[i], wrv[i], 32'h10, wd[i], 5'(i + 3), s, b, p, t);
      else       send(2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, s, b, p, t);
      vectors++;
      if (s !== LAT) begin miscompares++; $display("FAIL store_load_stall[%0d] got=%0d want=%0d", i, s, LAT); end
      if (s > 0) begin
        vectors++;
        if (!b) begin miscompares++; $display("FAIL store_load_bubble[%0d] got=nonzero want=0", i); end
      end
      obs = {WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst_mux_out};
      e = exp_q.pop_front(); m = mask_q.pop_front();
      vectors++;
      if ((obs & m) !== (e & m)) begin miscompares++; $display("FAIL store_load_wb[%0d] got=%h want=%h", i, obs & m, e & m); end
    end
  endtask

  task automatic test_wrap();
    int s; bit b; logic p; logic [31:0] t;
    logic [70:0] obs, e, m;
    send(2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h403, 32'h12345678, 5'd1, s, b, p, t);
    void'(exp_q.pop_front()); void'(mask_q.pop_front());
    send(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h000, 32'h0, 5'd2, s, b, p, t);
    obs = {WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst_mux_out};
    e = exp_q.pop_front(); m = mask_q.pop_front();
    vectors++;
    if (WB_mem_data !== 32'h12345678) begin miscompares++; $display("FAIL wrap_data got=%h want=12345678", WB_mem_data); end
    vectors++;
    if ((obs & m) !== (e & m)) begin miscompares++; $display("FAIL wrap_wb got=%h want=%h", obs & m, e & m); end
  endtask

  task automatic test_branch();
    int s; bit b; logic p; logic [31:0] t;
    logic [70:0] obs, e, m;
    for (int z = 1; z >= 0; z--) begin
      send(2'b00, 1'b1, 1'(z), 32'h40, 1'b0, 1'b0, 32'h10, 32'h0, 5'd0, s, b, p, t);
      vectors++;
      if (p !== 1'(z)) begin miscompares++; $display("FAIL branch_pc_src[z=%0d] got=%b want=%0d", z, p, z); end
      vectors++;
      if (t !== 32'h40) begin miscompares++; $display("FAIL branch_target[z=%0d] got=%h want=40", z, t); end
      vectors++;
      if (s !== 0) begin miscompares++; $display("FAIL branch_stall[z=%0d] got=%0d want=0", z, s); end
      obs = {WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst_mux_out};
      e = exp_q.pop_front(); m = mask_q.pop_front();
      vectors++;
      if ((obs & m) !== (e & m)) begin miscompares++; $display("FAIL branch_wb[z=%0d] got=%h want=%h", z, obs & m, e & m); end
    end
  endtask

  task automatic test_back_to_back();
    int s; bit b; logic p; logic [31:0] t;
    logic [70:0] obs, e, m;
    logic rd, wr;
    logic [31:0] a;
    for (int i = 0; i < 10; i++) begin
      a  = 32'h100 + 32'($urandom_range(0, 2) * 4);
      wr = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i < 3) a = 32'h100 + 32'(i * 4);
      send(2'($urandom_range(0, 3)), 1'b0, 1'b0, 32'h0, rd, wr, a, $urandom, 5'($urandom_range(0, 31)), s, b, p, t);
      vectors++;
      if (s !== LAT) begin miscompares++; $display("FAIL b2b_stall[%0d] got=%0d want=%0d", i, s, LAT); end
      obs = {WB_wb, WB_mem_data, WB_alu_result, WB_reg_dst_mux_out};
      e = exp_q.pop_front(); m = mask_q.pop_front();
      vectors++;
      if ((obs & m) !== (e & m)) begin miscompares++; $display("FAIL b2b_wb[%0d] got=%h want=%h", i, obs & m, e & m); end
    end
  endtask

  task automatic test_reset_wait();
    int s; bit b; logic p; logic [31:0] t;
    send(2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h55555555, 5'd4, s, b, p, t);
    void'(exp_q.pop_front()); void'(mask_q.pop_front());
    @(negedge clk);
    MEM_wb = 2'b11; MEM_mem_write = 1'b1; MEM_mem_read = 1'b0;
    MEM_alu_result = 32'h20; MEM_reg_data2 = 32'hAA; MEM_reg_dst_mux_out = 5'd6;
    #1;
    vectors++;
    if (mem_stall !== 1'b1) begin miscompares++; $display("FAIL abort_first_stall got=%b want=1", mem_stall); end
    @(posedge clk);
    @(negedge clk);
    startin = 1'b1;
    #1;
    vectors++;
    if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL abort_stall_in_reset got=%b want=0", mem_stall); end
    @(posedge clk); #1;
    vectors++;
    if (WB_alu_result !== 32'h0 || WB_wb !== 2'b00) begin
      miscompares++; $display("FAIL abort_wb_cleared got=%h/%b want=0/00", WB_alu_result, WB_wb);
    end
    @(negedge clk);
    startin = 1'b0; MEM_mem_write = 1'b0;
    #1;
    vectors++;
    if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL abort_idle_stall got=%b want=0", mem_stall); end
    send(2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 5'd8, s, b, p, t);
    void'(exp_q.pop_front()); void'(mask_q.pop_front());
    vectors++;
    if (s !== LAT) begin miscompares++; $display("FAIL abort_next_stall got=%0d want=%0d", s, LAT); end
    vectors++;
    if (WB_mem_data !== 32'h55555555) begin miscompares++; $display("FAIL abort_word_kept got=%h want=55555555", WB_mem_data); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_store_load();
    test_wrap();
    test_branch();
    test_back_to_back();
    if (LAT > 0) test_reset_wait();
    go_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
